// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between an instruction-fetch
// port and a load/store port. Round-robin on contention; reads take two
// cycles (grant + data return), stores one.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              resetn,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    // data load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wmask,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // RAM side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    state_t state_q, state_d;
    src_t   owner_q, owner_d;
    src_t   last_q,  last_d;
    src_t   winner;

    // Round-robin pick: a lone requester wins; on contention the port not granted last wins
    always_comb begin
        winner = SRC_I;
        if (d_req && (!i_req || (last_q == SRC_I))) begin
            winner = SRC_D;
        end
    end

    // Next-state and RAM/handshake outputs; everything quiet while resetn is low
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        mem_addr  = ADDR_W'(0);
        mem_rden  = 1'b0;
        mem_wmask = MASK_W'(0);
        mem_wdata = DATA_W'(0);
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        last_d = winner;
                        if (winner == SRC_D) begin
                            d_gnt    = 1'b1;
                            mem_addr = d_addr;
                            if (d_we) begin
                                // store retires in the grant cycle, no data phase
                                mem_wmask = d_wmask;
                                mem_wdata = d_wdata;
                            end else begin
                                mem_rden = 1'b1;
                                owner_d  = SRC_D;
                                state_d  = RD_WAIT;
                            end
                        end else begin
                            i_gnt    = 1'b1;
                            mem_addr = i_addr;
                            mem_rden = 1'b1;
                            owner_d  = SRC_I;
                            state_d  = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // RAM data is on mem_rdata this cycle; new requests wait for IDLE
                    i_rvalid = (owner_q == SRC_I);
                    d_rvalid = (owner_q == SRC_D);
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= SRC_I;
            last_q  <= SRC_I;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Read data is shared; only meaningful alongside the matching rvalid
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: RAM model, per-cycle reference model and
// directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;

    logic              CLK;
    logic              resetn;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wmask;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_wmask   (d_wmask),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_rden  (mem_rden),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM behind the arbiter (256 words) and the model's own copy of memory
    logic [31:0] ram     [256];
    logic [31:0] mdl_mem [256];

    initial begin
        for (int k = 0; k < 256; k++) begin
            ram[k]     = 32'h0A000000 + 32'(k);
            mdl_mem[k] = 32'h0A000000 + 32'(k);
        end
        ram[4]     = 32'h00100073;
        mdl_mem[4] = 32'h00100073;
        ram[8]     = 32'h11223344;
        mdl_mem[8] = 32'h11223344;
    end

    // Registered-read, byte-writable single-port RAM
    always @(posedge CLK) begin
        if (mem_rden) mem_rdata <= ram[mem_addr[9:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    // Reference model: a read occupies the port for one extra cycle, reset clears
    // it and hands the next contention to the data port.
    logic        m_busy  = 1'b0;
    logic        m_own_d = 1'b0;
    logic        m_last_d = 1'b0;
    logic [31:0] m_data  = 32'h0;

    always @(negedge CLK) begin : model
        logic        e_ig, e_dg, e_ir, e_dr, e_rden, pick_d;
        logic [3:0]  e_wm;
        logic [31:0] e_addr;
        logic [7:0]  idx;
        e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_rden = 0; e_wm = 4'h0;
        e_addr = 32'h0;
        if (!resetn) begin
            m_busy   = 1'b0;
            m_last_d = 1'b0;
        end else if (m_busy) begin
            e_ir   = !m_own_d;
            e_dr   = m_own_d;
            m_busy = 1'b0;
        end else if (i_req || d_req) begin
            pick_d   = d_req && !(i_req && m_last_d);
            m_last_d = pick_d;
            e_ig     = !pick_d;
            e_dg     = pick_d;
            e_addr   = pick_d ? d_addr : i_addr;
            idx      = e_addr[9:2];
            if (pick_d && d_we) begin
                e_wm = d_wmask;
                for (int b = 0; b < 4; b++)
                    if (d_wmask[b]) mdl_mem[idx][b*8 +: 8] = d_wdata[b*8 +: 8];
            end else begin
                e_rden  = 1'b1;
                m_busy  = 1'b1;
                m_own_d = pick_d;
                m_data  = mdl_mem[idx];
            end
        end
        chk("handshake", {28'h0, i_gnt, d_gnt, i_rvalid, d_rvalid}, {28'h0, e_ig, e_dg, e_ir, e_dr});
        chk("mem_ctrl", {27'h0, mem_rden, mem_wmask}, {27'h0, e_rden, e_wm});
        if (e_ig || e_dg) chk("mem_addr", mem_addr, e_addr);
        if (e_wm != 4'h0) chk("mem_wdata", mem_wdata, d_wdata);
        if (e_ir) chk("i_rdata", i_rdata, m_data);
        if (e_dr) chk("d_rdata", d_rdata, m_data);
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic d_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
        d_req = req; d_we = we; d_addr = addr; d_wmask = mask; d_wdata = data;
    endtask

    logic [1:0] rr_pat [8];

    initial begin
        rr_pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        resetn = 1'b0; i_req = 1'b0; i_addr = 32'h0;
        d_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) cyc();
        resetn = 1'b1;

        // fetch only
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge CLK);
        chk("fetch_gnt", {30'h0, i_gnt, mem_rden}, 32'h3);
        chk("fetch_addr", mem_addr, 32'h10);
        cyc(); i_req = 1'b0;
        @(negedge CLK);
        chk("fetch_rvalid", {31'h0, i_rvalid}, 32'h1);
        chk("fetch_rdata", i_rdata, 32'h00100073);

        // store then load back
        cyc(); d_set(1'b1, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF);
        @(negedge CLK);
        chk("store_gnt", {27'h0, d_gnt, mem_wmask}, {27'h0, 1'b1, 4'hF});
        cyc(); d_we = 1'b0;
        @(negedge CLK);
        chk("load_gnt", {30'h0, d_gnt, mem_rden}, 32'h3);
        cyc(); d_req = 1'b0;
        @(negedge CLK);
        chk("load_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("load_rdata", d_rdata, 32'hDEADBEEF);

        // byte store merge
        cyc(); d_set(1'b1, 1'b1, 32'h20, 4'h2, 32'h0000AB00);
        cyc(); d_we = 1'b0;
        cyc(); d_req = 1'b0;
        @(negedge CLK);
        chk("byte_merge", d_rdata, 32'h1122AB44);

        // store with empty mask changes nothing
        cyc(); d_set(1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
        @(negedge CLK);
        chk("zmask_gnt", {27'h0, d_gnt, mem_wmask}, 32'h10);
        cyc(); d_we = 1'b0;
        cyc(); d_req = 1'b0;
        @(negedge CLK);
        chk("zmask_rdata", d_rdata, 32'h1122AB44);

        // data request arriving during a fetch's read wait
        cyc(); i_req = 1'b1; i_addr = 32'h10;
        cyc(); i_req = 1'b0; d_set(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        @(negedge CLK);
        chk("rdwait_hold", {30'h0, d_gnt, i_rvalid}, 32'h1);
        cyc();
        @(negedge CLK);
        chk("rdwait_next", {31'h0, d_gnt}, 32'h1);
        cyc(); d_req = 1'b0;

        // reset in the middle of a load
        cyc(); d_set(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        cyc(); d_req = 1'b0; resetn = 1'b0;
        @(negedge CLK);
        chk("abort_rvalid0", {31'h0, d_rvalid}, 32'h0);
        cyc(); resetn = 1'b1;
        @(negedge CLK);
        chk("abort_rvalid1", {31'h0, d_rvalid}, 32'h0);

        // contention after reset: D, I, D, I with a read wait between each
        cyc(); i_req = 1'b1; i_addr = 32'h10; d_set(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            chk("rr_order", {30'h0, i_gnt, d_gnt}, {30'h0, rr_pat[c]});
            cyc();
        end

        // grants suppressed while reset is held with both ports requesting
        resetn = 1'b0;
        @(negedge CLK);
        chk("rst_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
        cyc(); resetn = 1'b1;
        @(negedge CLK);
        chk("post_rst_d", {30'h0, i_gnt, d_gnt}, 32'h1);
        cyc(); i_req = 1'b0; d_req = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
